ysyx_23060201_regfile: RTL

Parametrised general-purpose register file for the pipelined NPC core, replacing the single-issue GPR. It adds a configurable number of read ports, same-cycle write-to-read bypass, a hardware clear sequence after reset, and a per-register pending scoreboard for RAW/WAW hazard detection. It sits between the decode/issue stage (reads, issue) and the write-back stage (writes).

---
 rtl/ysyx_23060201_rf_pkg.sv | 12 +
 rtl/ysyx_23060201_scoreboard.sv | 66 ++++++
 rtl/ysyx_23060201_regfile.sv | 112 +++++++++++
 3 files changed

// File: rtl/ysyx_23060201_rf_pkg.sv
// rtl/ysyx_23060201_rf_pkg.sv - shared types and defaults for the register file
package ysyx_23060201_rf_pkg;

  localparam int RF_ADDR_WIDTH_DEF = 5;
  localparam int RF_DATA_WIDTH_DEF = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/ysyx_23060201_scoreboard.sv
// rtl/ysyx_23060201_scoreboard.sv - per-register pending bits with RAW/WAW hazard outputs
module ysyx_23060201_scoreboard
  import ysyx_23060201_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
  parameter int NR_RPORTS  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  rf_state_e                      state_i,
  input  logic                           wen_i,
  input  logic [ADDR_WIDTH-1:0]          waddr_i,
  input  logic                           issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]          issue_addr_i,
  input  logic [NR_RPORTS-1:0]           ren_i,
  input  logic [NR_RPORTS*ADDR_WIDTH-1:0] raddr_i,
  output logic [NR_RPORTS-1:0]           rbusy_o,
  output logic                           issue_ready_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] pending_q, pending_d;
  logic             run;
  logic             wen_eff;
  logic             issue_acc;

  assign run     = (state_i == RF_RUN);
  assign wen_eff = run && wen_i;

  // A write landing this cycle on the stalled destination releases the WAW stall at once.
  assign issue_ready_o = run &&
                         !(pending_q[issue_addr_i] && !(wen_eff && (waddr_i == issue_addr_i)));
  assign issue_acc     = issue_valid_i && issue_ready_o;

  // Next pending vector: clear on write, then set on issue so the set wins on a collision.
  always_comb begin
    pending_d = pending_q;
    if (wen_eff) begin
      pending_d[waddr_i] = 1'b0;
    end
    if (issue_acc) begin
      pending_d[issue_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pending_d[0] = 1'b0;
    end
  end

  // Pending register; reset drops every outstanding destination.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < NR_RPORTS; i++) begin : g_busy
    logic [ADDR_WIDTH-1:0] ra;
    assign ra         = raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rbusy_o[i] = ren_i[i] && pending_q[ra] && !(wen_eff && (waddr_i == ra));
  end

endmodule

// File: rtl/ysyx_23060201_regfile.sv
// rtl/ysyx_23060201_regfile.sv - multi-port GPR file with bypass, clear sweep and scoreboard
module ysyx_23060201_regfile
  import ysyx_23060201_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = RF_DATA_WIDTH_DEF,
  parameter int NR_RPORTS  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            init_done,
  input  logic [NR_RPORTS-1:0]            ren,
  input  logic [NR_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NR_RPORTS-1:0]            rbusy,
  input  logic                            wen,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            issue_valid,
  input  logic [ADDR_WIDTH-1:0]           issue_addr,
  output logic                            issue_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  run;
  logic                  sweep_we;
  logic                  wen_eff;
  logic                  wr_en;

  assign run       = (state_q == RF_RUN);
  assign init_done = run;
  assign wen_eff   = run && wen;
  assign wr_en     = wen_eff && !((ZERO_REG != 0) && (waddr == '0));

  // Sweep FSM: walk every index writing zero, then hand over to normal operation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_we = 1'b0;
    unique case (state_q)
      RF_CLEAR: begin
        sweep_we = 1'b1;
        idx_d    = idx_q + ADDR_WIDTH'(1);
        if (idx_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  // State and sweep index registers; reset restarts the sweep from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage: the sweep owns the write port until it finishes; reset itself writes nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        mem_q[idx_q] <= '0;
      end else if (wr_en) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  for (genvar i = 0; i < NR_RPORTS; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  zero_hit;
    assign ra       = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] =
        (!run || !ren[i] || zero_hit) ? '0 :
        (wen_eff && (waddr == ra))    ? wdata : mem_q[ra];
  end

  ysyx_23060201_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NR_RPORTS (NR_RPORTS),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_i        (rst),
    .state_i      (state_q),
    .wen_i        (wen),
    .waddr_i      (waddr),
    .issue_valid_i(issue_valid),
    .issue_addr_i (issue_addr),
    .ren_i        (ren),
    .raddr_i      (raddr),
    .rbusy_o      (rbusy),
    .issue_ready_o(issue_ready)
  );

endmodule
